// File: rtl/boolean_unit_arbiter_pkg.sv
// rtl/boolean_unit_arbiter_pkg.sv - op encodings and bit-level helper for the shared Boolean unit
package boolean_unit_arbiter_pkg;

`include "Dyadic_Boolean_Operations.sv"

    localparam logic [3:0] OP_AND  = `DBO_AND;
    localparam logic [3:0] OP_OR   = `DBO_OR;
    localparam logic [3:0] OP_XOR  = `DBO_XOR;
    localparam logic [3:0] OP_NAND = `DBO_NAND;
    localparam logic [3:0] OP_A    = `DBO_A;
    localparam logic [3:0] OP_B    = `DBO_B;
    localparam logic [3:0] OP_ZERO = `DBO_ZERO;
    localparam logic [3:0] OP_ONE  = `DBO_ONE;

    // The op is a truth table indexed by {a, b}.
    function automatic logic bool_bit(input logic [3:0] op, input logic a, input logic b);
        return op[{a, b}];
    endfunction

endpackage

// File: rtl/Dyadic_Boolean_Operations.sv
// rtl/Dyadic_Boolean_Operations.sv - shared truth-table encodings for dyadic Boolean ops
`ifndef DYADIC_BOOLEAN_OPERATIONS_SV
`define DYADIC_BOOLEAN_OPERATIONS_SV

`define DBO_AND  4'b1000
`define DBO_OR   4'b1110
`define DBO_XOR  4'b0110
`define DBO_NAND 4'b0111
`define DBO_A    4'b1100
`define DBO_B    4'b1010
`define DBO_ZERO 4'b0000
`define DBO_ONE  4'b1111

`endif

// File: rtl/Dyadic_Boolean_Operator.sv
// rtl/Dyadic_Boolean_Operator.sv - bitwise truth-table Boolean unit
module Dyadic_Boolean_Operator
    import boolean_unit_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [3:0]            op,
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic [WORD_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        for (int k = 0; k < WORD_WIDTH; k++) begin
            result[k] = bool_bit(op, a[k], b[k]);
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - one-hot winner search ascending from a rotating pointer
module rr_priority_arbiter #(
    parameter int REQUESTER_COUNT = 4,
    parameter int ID_WIDTH        = 2
) (
    input  logic [REQUESTER_COUNT-1:0] requests,
    input  logic [ID_WIDTH-1:0]        pointer,
    output logic [REQUESTER_COUNT-1:0] grant
);

    always_comb begin
        logic [ID_WIDTH:0] idx;
        logic              found;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            // Extra bit keeps the modulo wrap correct for non-power-of-two counts.
            idx = {1'b0, pointer} + (ID_WIDTH+1)'(i);
            if (idx >= (ID_WIDTH+1)'(REQUESTER_COUNT)) begin
                idx = idx - (ID_WIDTH+1)'(REQUESTER_COUNT);
            end
            if (!found && requests[idx[ID_WIDTH-1:0]]) begin
                grant[idx[ID_WIDTH-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/boolean_unit_arbiter.sv
// rtl/boolean_unit_arbiter.sv - round-robin sharing of one Boolean unit with a one-entry result register
module boolean_unit_arbiter
    import boolean_unit_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH      = 32,
    parameter int REQUESTER_COUNT = 4,
    parameter int ID_WIDTH        = 2
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [REQUESTER_COUNT-1:0]           req_valid,
    output logic [REQUESTER_COUNT-1:0]           req_ready,
    input  logic [4*REQUESTER_COUNT-1:0]         req_op,
    input  logic [WORD_WIDTH*REQUESTER_COUNT-1:0] req_a,
    input  logic [WORD_WIDTH*REQUESTER_COUNT-1:0] req_b,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic [WORD_WIDTH-1:0]                result_data,
    output logic [ID_WIDTH-1:0]                  result_id
);

    logic [ID_WIDTH-1:0]        ptr_q, ptr_d;
    logic                       result_valid_q, result_valid_d;
    logic [WORD_WIDTH-1:0]      result_data_q, result_data_d;
    logic [ID_WIDTH-1:0]        result_id_q, result_id_d;

    logic [REQUESTER_COUNT-1:0] winner;
    logic                       slot_free;
    logic                       grant;
    logic [ID_WIDTH-1:0]        grant_id;

    logic [3:0]                 op_arr [REQUESTER_COUNT];
    logic [WORD_WIDTH-1:0]      a_arr  [REQUESTER_COUNT];
    logic [WORD_WIDTH-1:0]      b_arr  [REQUESTER_COUNT];
    logic [3:0]                 sel_op;
    logic [WORD_WIDTH-1:0]      sel_a, sel_b, unit_result;

    rr_priority_arbiter #(
        .REQUESTER_COUNT(REQUESTER_COUNT),
        .ID_WIDTH       (ID_WIDTH)
    ) u_rr_priority_arbiter (
        .requests(req_valid),
        .pointer (ptr_q),
        .grant   (winner)
    );

    // The slot frees up in the same cycle the consumer takes the held result.
    assign slot_free = !result_valid_q || result_ready;
    assign req_ready = (reset_n && slot_free) ? winner : '0;
    assign grant     = |req_ready;

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (winner[i]) begin
                grant_id = ID_WIDTH'(i);
            end
        end
    end

    for (genvar i = 0; i < REQUESTER_COUNT; i++) begin : g_unpack
        assign op_arr[i] = req_op[4*i +: 4];
        assign a_arr[i]  = req_a[WORD_WIDTH*i +: WORD_WIDTH];
        assign b_arr[i]  = req_b[WORD_WIDTH*i +: WORD_WIDTH];
    end

    assign sel_op = op_arr[grant_id];
    assign sel_a  = a_arr[grant_id];
    assign sel_b  = b_arr[grant_id];

    Dyadic_Boolean_Operator #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_dyadic_boolean_operator (
        .op    (sel_op),
        .a     (sel_a),
        .b     (sel_b),
        .result(unit_result)
    );

    always_comb begin
        ptr_d          = ptr_q;
        result_valid_d = result_valid_q;
        result_data_d  = result_data_q;
        result_id_d    = result_id_q;
        if (grant) begin
            result_valid_d = 1'b1;
            result_data_d  = unit_result;
            result_id_d    = grant_id;
            ptr_d          = (grant_id == ID_WIDTH'(REQUESTER_COUNT-1)) ? '0 : grant_id + ID_WIDTH'(1);
        end else if (result_ready) begin
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q          <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            result_id_q    <= '0;
        end else begin
            ptr_q          <= ptr_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            result_id_q    <= result_id_d;
        end
    end

    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign result_id    = result_id_q;

endmodule

// File: tb/tb_boolean_unit_arbiter.sv
// tb/tb_boolean_unit_arbiter.sv - directed self-checking bench for boolean_unit_arbiter
module tb_boolean_unit_arbiter;
    import boolean_unit_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        result_valid;
    logic        result_ready;
    logic [7:0]  result_data;
    logic [1:0]  result_id;

    int checks = 0;
    int errors = 0;

    boolean_unit_arbiter #(
        .WORD_WIDTH     (8),
        .REQUESTER_COUNT(4),
        .ID_WIDTH       (2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_data (result_data),
        .result_id   (result_id)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_valid[i]      = v;
        req_op[4*i +: 4]  = op;
        req_a[8*i +: 8]   = a;
        req_b[8*i +: 8]   = b;
    endtask

    task automatic apply_reset;
        reset_n      = 1'b0;
        req_valid    = '0;
        result_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        reset_n      = 1'b0;
        req_valid    = 4'hF;
        req_op       = {OP_ONE, OP_ONE, OP_ONE, OP_ONE};
        req_a        = 32'hFFFF_FFFF;
        req_b        = 32'hFFFF_FFFF;
        result_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            checks++;
            if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", result_valid); end
            checks++;
            if (result_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", result_data); end
            checks++;
            if (result_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", result_id); end
            checks++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        end
        reset_n   = 1'b1;
        req_valid = '0;
        #1;
    endtask

    task automatic test_single;
        apply_reset;
        set_req(1, 1'b1, OP_AND, 8'hF0, 8'hCC);
        result_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b want 0010", req_ready); end
        tick;
        req_valid = '0;
        checks++;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", result_valid); end
        checks++;
        if (result_data !== 8'hC0) begin errors++; $display("FAIL single_data: got %h want c0", result_data); end
        checks++;
        if (result_id !== 2'd1) begin errors++; $display("FAIL single_id: got %0d want 1", result_id); end
        tick;
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", result_valid); end
    endtask

    // Pointer is 2 after test_single, so each lone requester below is the next in rotation.
    task automatic test_ops;
        logic [3:0] ops  [7];
        logic [7:0] exps [7];
        int         id;
        ops  = '{OP_XOR, OP_OR, OP_NAND, OP_ONE, OP_A, OP_B, OP_ZERO};
        exps = '{8'h3C, 8'hFC, 8'h3F, 8'hFF, 8'hF0, 8'hCC, 8'h00};
        result_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            id = (k + 2) % 4;
            req_valid = '0;
            set_req(id, 1'b1, ops[k], 8'hF0, 8'hCC);
            #1;
            checks++;
            if (req_ready !== (4'b0001 << id)) begin errors++; $display("FAIL ops_ready[%0d]: got %b want %b", k, req_ready, 4'b0001 << id); end
            tick;
            checks++;
            if (result_data !== exps[k]) begin errors++; $display("FAIL ops_data[%0d]: got %h want %h", k, result_data, exps[k]); end
            checks++;
            if (result_id !== 2'(id)) begin errors++; $display("FAIL ops_id[%0d]: got %0d want %0d", k, result_id, id); end
        end
        req_valid = '0;
        tick;
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL ops_drain: got %b want 0", result_valid); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_data;
        int         exp_id;
        apply_reset;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b1, OP_A, 8'(17 * (i + 1)), 8'h00);
        end
        result_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_id   = k % 4;
            exp_data = 8'(17 * (exp_id + 1));
            #1;
            checks++;
            if (req_ready !== (4'b0001 << exp_id)) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'b0001 << exp_id); end
            tick;
            checks++;
            if (result_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b want 1", k, result_valid); end
            checks++;
            if (result_id !== 2'(exp_id)) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, result_id, exp_id); end
            checks++;
            if (result_data !== exp_data) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, result_data, exp_data); end
        end
    endtask

    // Continues from test_back_to_back: result id 0 held, pointer at 1.
    task automatic test_backpressure;
        result_ready = 1'b0;
        req_valid    = 4'b0101;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready); end
            checks++;
            if (result_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", k, result_valid); end
            checks++;
            if (result_data !== 8'h11) begin errors++; $display("FAIL bp_data[%0d]: got %h want 11", k, result_data); end
            checks++;
            if (result_id !== 2'd0) begin errors++; $display("FAIL bp_id[%0d]: got %0d want 0", k, result_id); end
            tick;
        end
        result_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b want 0100", req_ready); end
        tick;
        checks++;
        if (result_id !== 2'd2) begin errors++; $display("FAIL bp_release_id: got %0d want 2", result_id); end
        checks++;
        if (result_data !== 8'h33) begin errors++; $display("FAIL bp_release_data: got %h want 33", result_data); end
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_ready: got %b want 0001", req_ready); end
        tick;
        checks++;
        if (result_id !== 2'd0) begin errors++; $display("FAIL bp_next_id: got %0d want 0", result_id); end
        req_valid = '0;
    endtask

    task automatic test_wrap;
        apply_reset;
        result_ready = 1'b1;
        set_req(2, 1'b1, OP_XOR, 8'hF0, 8'hCC);
        #1;
        tick;
        checks++;
        if (result_id !== 2'd2) begin errors++; $display("FAIL wrap_setup_id: got %0d want 2", result_id); end
        set_req(3, 1'b1, OP_OR, 8'hF0, 8'hCC);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first_ready: got %b want 1000", req_ready); end
        tick;
        checks++;
        if (result_id !== 2'd3) begin errors++; $display("FAIL wrap_first_id: got %0d want 3", result_id); end
        checks++;
        if (result_data !== 8'hFC) begin errors++; $display("FAIL wrap_first_data: got %h want fc", result_data); end
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_second_ready: got %b want 0100", req_ready); end
        tick;
        checks++;
        if (result_id !== 2'd2) begin errors++; $display("FAIL wrap_second_id: got %0d want 2", result_id); end
        checks++;
        if (result_data !== 8'h3C) begin errors++; $display("FAIL wrap_second_data: got %h want 3c", result_data); end
        req_valid = '0;
    endtask

    task automatic test_async_reset;
        apply_reset;
        result_ready = 1'b1;
        set_req(1, 1'b1, OP_AND, 8'hF0, 8'hCC);
        #1;
        tick;
        result_ready = 1'b0;
        set_req(0, 1'b1, OP_OR, 8'hF0, 8'hCC);
        set_req(2, 1'b1, OP_XOR, 8'hF0, 8'hCC);
        set_req(3, 1'b1, OP_NAND, 8'hF0, 8'hCC);
        #1;
        checks++;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", result_valid); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", result_valid); end
        checks++;
        if (result_data !== 8'h00) begin errors++; $display("FAIL areset_data: got %h want 00", result_data); end
        checks++;
        if (result_id !== 2'd0) begin errors++; $display("FAIL areset_id: got %0d want 0", result_id); end
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL areset_ready: got %b want 0000", req_ready); end
        #1;
        reset_n      = 1'b1;
        result_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL areset_after_ready: got %b want 0001", req_ready); end
        tick;
        checks++;
        if (result_id !== 2'd0) begin errors++; $display("FAIL areset_after_id: got %0d want 0", result_id); end
        checks++;
        if (result_data !== 8'hFC) begin errors++; $display("FAIL areset_after_data: got %h want fc", result_data); end
        req_valid = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_ops;
        test_back_to_back;
        test_backpressure;
        test_wrap;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
